// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - four-digit multiplexed seven-segment display scanner
//
// Time-multiplexes four digit codes onto one set of seven segment drives plus a
// decimal point. Each digit slot lasts SCAN_DIV clocks. The first BLANK_CYCLES
// clocks of every slot are dark, to avoid ghosting. New data is captured into a
// shadow register by Update and is shown only from the next frame boundary.
//
// Ports:
//   Clock              sole clock, rising edge
//   Reset              asynchronous, active-high
//   D0..D3 [3:0]       digit codes (D0 rightmost)
//   DPSel  [3:0]       decimal-point enable, bit i belongs to Di
//   Update             strobe loading D0..D3/DPSel into the shadow register
//   SegA..SegG, DP     active-high segment and decimal-point drives
//   nDigit [3:0]       active-low one-hot digit enable, 4'b1111 = none
//   FrameDone          one-cycle pulse at the start of each frame
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on
// digits 3..1.
module display_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] D0,
  input  logic [3:0] D1,
  input  logic [3:0] D2,
  input  logic [3:0] D3,
  input  logic [3:0] DPSel,
  input  logic       Update,
  output logic       SegA,
  output logic       SegB,
  output logic       SegC,
  output logic       SegD,
  output logic       SegE,
  output logic       SegF,
  output logic       SegG,
  output logic       DP,
  output logic [3:0] nDigit,
  output logic       FrameDone
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

  logic [PW-1:0]   presc, nxt_presc;
  logic [1:0]      idx, nxt_idx;
  logic [3:0][3:0] sh_d, nxt_sh_d, act_d, nxt_act_d;
  logic [3:0]      sh_dp, nxt_sh_dp, act_dp, nxt_act_dp;

  logic [6:0]      seg_q, nxt_seg;
  logic            dp_q, nxt_dp;
  logic [3:0]      ndig_q, nxt_ndig;
  logic            fd_q;

  logic            wrap, boundary, in_blank, digit_off;
  logic [3:0]      lz;
  logic [3:0]      code;

  // Segment pattern packed as {A,B,C,D,E,F,G}.
  function automatic logic [6:0] seg_decode(input logic [3:0] c);
    case (c)
      4'h0:    seg_decode = 7'b1111110;
      4'h1:    seg_decode = 7'b0110000;
      4'h2:    seg_decode = 7'b1101101;
      4'h3:    seg_decode = 7'b1111001;
      4'h4:    seg_decode = 7'b0110011;
      4'h5:    seg_decode = 7'b1011011;
      4'h6:    seg_decode = 7'b1011111;
      4'h7:    seg_decode = 7'b1110000;
      4'h8:    seg_decode = 7'b1111111;
      4'h9:    seg_decode = 7'b1111011;
      4'hA:    seg_decode = 7'b0000001;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  // The output registers are loaded from the *next* scan state so that they
  // line up with presc/idx in the same cycle instead of trailing by one.
  always_comb begin
    wrap       = (presc == PRESC_LAST);
    boundary   = wrap && (idx == 2'd3);
    nxt_presc  = wrap ? '0 : presc + 1'b1;
    nxt_idx    = wrap ? idx + 2'd1 : idx;

    nxt_sh_d   = Update ? {D3, D2, D1, D0} : sh_d;
    nxt_sh_dp  = Update ? DPSel : sh_dp;
    // Taking the post-Update shadow means a strobe on the boundary edge goes
    // straight through to the active register.
    nxt_act_d  = boundary ? nxt_sh_d  : act_d;
    nxt_act_dp = boundary ? nxt_sh_dp : act_dp;

`ifdef LEADING_ZERO_BLANK_EN
    lz[3] = (nxt_act_d[3] == 4'h0) && !nxt_act_dp[3];
    lz[2] = lz[3] && (nxt_act_d[2] == 4'h0) && !nxt_act_dp[2];
    lz[1] = lz[2] && (nxt_act_d[1] == 4'h0) && !nxt_act_dp[1];
    lz[0] = 1'b0;
`else
    lz    = 4'b0000;
`endif

    code      = nxt_act_d[nxt_idx];
    in_blank  = (nxt_presc < BLANK_END);
    digit_off = lz[nxt_idx];

    nxt_seg  = 7'b0000000;
    nxt_dp   = 1'b0;
    nxt_ndig = 4'b1111;
    if (!in_blank) begin
      nxt_ndig = ~(4'b0001 << nxt_idx);
      if (!digit_off) begin
        nxt_seg = seg_decode(code);
        nxt_dp  = nxt_act_dp[nxt_idx];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      presc  <= '0;
      idx    <= 2'd0;
      sh_d   <= {4{4'hF}};
      act_d  <= {4{4'hF}};
      sh_dp  <= 4'b0000;
      act_dp <= 4'b0000;
      seg_q  <= 7'b0000000;
      dp_q   <= 1'b0;
      ndig_q <= 4'b1111;
      fd_q   <= 1'b0;
    end else begin
      presc  <= nxt_presc;
      idx    <= nxt_idx;
      sh_d   <= nxt_sh_d;
      act_d  <= nxt_act_d;
      sh_dp  <= nxt_sh_dp;
      act_dp <= nxt_act_dp;
      seg_q  <= nxt_seg;
      dp_q   <= nxt_dp;
      ndig_q <= nxt_ndig;
      // High in the idx 0 / presc 0 cycle that follows a boundary; never
      // after reset because no boundary edge has happened yet.
      fd_q   <= boundary;
    end
  end

  assign {SegA, SegB, SegC, SegD, SegE, SegF, SegG} = seg_q;
  assign DP        = dp_q;
  assign nDigit    = ndig_q;
  assign FrameDone = fd_q;

endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - directed self-checking bench for display_scanner
module tb_display_scanner;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] D0 = 4'h0, D1 = 4'h0, D2 = 4'h0, D3 = 4'h0, DPSel = 4'h0;
  logic       Update = 1'b0;
  logic       SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP, FrameDone;
  logic [3:0] nDigit;

  int checks = 0;
  int errors = 0;

  logic [6:0] e_seg [4];
  logic       e_dp  [4];

  display_scanner #(.SCAN_DIV(4), .BLANK_CYCLES(1)) dut (
    .Clock(Clock), .Reset(Reset),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .DPSel(DPSel), .Update(Update),
    .SegA(SegA), .SegB(SegB), .SegC(SegC), .SegD(SegD), .SegE(SegE),
    .SegF(SegF), .SegG(SegG), .DP(DP), .nDigit(nDigit), .FrameDone(FrameDone)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, ".ndig"}, {4'h0, nDigit}, 8'h0F);
    chk({tag, ".seg"}, {1'b0, SegA, SegB, SegC, SegD, SegE, SegF, SegG}, 8'h00);
    chk({tag, ".dp"}, {7'h0, DP}, 8'h00);
    chk({tag, ".fd"}, {7'h0, FrameDone}, 8'h00);
  endtask

  task automatic set_slots(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dps);
    e_seg[0] = s0; e_seg[1] = s1; e_seg[2] = s2; e_seg[3] = s3;
    for (int i = 0; i < 4; i++) e_dp[i] = dps[i];
  endtask

  // Runs one 16-cycle frame from offset 0, checking every cycle against
  // e_seg/e_dp. Update is driven for upd_len cycles from upd_off (data d_a
  // for all but the last cycle, d_b on the last). rst_off >= 0 aborts the
  // frame with a reset pulse at that offset.
  task automatic run_frame(input string name, input bit first,
                           input int upd_off, input int upd_len,
                           input logic [15:0] d_a, input logic [3:0] p_a,
                           input logic [15:0] d_b, input logic [3:0] p_b,
                           input int rst_off);
    logic [3:0] en;
    logic [6:0] es;
    logic       ed, ef;
    for (int k = 0; k < 16; k++) begin
      int slot, p;
      slot = k / 4;
      p    = k % 4;
      case (slot)
        0: en = 4'b1110;
        1: en = 4'b1101;
        2: en = 4'b1011;
        default: en = 4'b0111;
      endcase
      if (p == 0) begin en = 4'b1111; es = 7'h00; ed = 1'b0; end
      else begin es = e_seg[slot]; ed = e_dp[slot]; end
      ef = (k == 0) && !first;
      chk($sformatf("%s.k%0d.ndig", name, k), {4'h0, nDigit}, {4'h0, en});
      chk($sformatf("%s.k%0d.seg", name, k),
          {1'b0, SegA, SegB, SegC, SegD, SegE, SegF, SegG}, {1'b0, es});
      chk($sformatf("%s.k%0d.dp", name, k), {7'h0, DP}, {7'h0, ed});
      chk($sformatf("%s.k%0d.fd", name, k), {7'h0, FrameDone}, {7'h0, ef});
      if (k == rst_off) begin
        Reset = 1'b1;
        #1;
        chk_blank($sformatf("%s.rst_now", name));
        step();
        chk_blank($sformatf("%s.rst_held", name));
        Update = 1'b0;
        Reset  = 1'b0;
        return;
      end
      if (k >= upd_off && k < upd_off + upd_len) begin
        Update = 1'b1;
        if (k == upd_off + upd_len - 1) begin
          {D3, D2, D1, D0} = d_b; DPSel = p_b;
        end else begin
          {D3, D2, D1, D0} = d_a; DPSel = p_a;
        end
      end else begin
        Update = 1'b0;
      end
      step();
    end
    Update = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk_blank("reset");
    Reset = 1'b0;

    // Idle after reset: digits hold code F, nothing lit; load 1,2,3,4 at index 1.
    set_slots(7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);
    run_frame("idle", 1'b1, 5, 1, 16'h1234, 4'b0100, 16'h1234, 4'b0100, -1);

    // 4 BCFG, 3 ABCDG, 2 ABDEG+DP, 1 BC; load D0=8 at index 1.
    set_slots(7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 4'b0100);
    run_frame("f1234", 1'b0, 5, 1, 16'h1238, 4'b0100, 16'h1238, 4'b0100, -1);

    // D0=8 now lit; strobe 0,0,7,0 exactly on the boundary cycle.
    set_slots(7'b1111111, 7'b1111001, 7'b1101101, 7'b0110000, 4'b0100);
    run_frame("f1238", 1'b0, 15, 1, 16'h0070, 4'b0000, 16'h0070, 4'b0000, -1);

`ifdef LEADING_ZERO_BLANK_EN
    set_slots(7'b1111110, 7'b1110000, 7'h00, 7'h00, 4'b0000);
`else
    set_slots(7'b1111110, 7'b1110000, 7'b1111110, 7'b1111110, 4'b0000);
`endif
    run_frame("f0070", 1'b0, 3, 1, 16'h95CA, 4'b0001, 16'h95CA, 4'b0001, -1);

    // A = minus only, C = dark but enabled, 5 ACDFG, 9 ABCDFG; Update held
    // for three cycles, last value wins.
    set_slots(7'b0000001, 7'h00, 7'b1011011, 7'b1111011, 4'b0001);
    run_frame("f95CA", 1'b0, 2, 3, 16'h6666, 4'b1111, 16'h0006, 4'b0010, -1);

    // Digit 1 is zero but carries a DP, so leading-zero blanking stops there.
`ifdef LEADING_ZERO_BLANK_EN
    set_slots(7'b1011111, 7'b1111110, 7'h00, 7'h00, 4'b0010);
`else
    set_slots(7'b1011111, 7'b1111110, 7'b1111110, 7'b1111110, 4'b0010);
`endif
    run_frame("f0006", 1'b0, 5, 1, 16'h8888, 4'b0000, 16'h8888, 4'b0000, 10);

    // After a mid-frame reset the pending 8888 is discarded.
    set_slots(7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);
    run_frame("post_rst", 1'b1, -1, 0, 16'h0, 4'h0, 16'h0, 4'h0, -1);
    run_frame("post_rst2", 1'b0, -1, 0, 16'h0, 4'h0, 16'h0, 4'h0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
